// File: rtl/aes_pkg.sv
// Shared AES definitions: encryptor FSM state encoding, round count,
// initial round constant, GF(2^8) xtime and the forward S-box.
// No ports (package).
package aes_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [3:0] NR        = 4'd10;
  localparam logic [7:0] RCON_INIT = 8'h01;

  // Forward S-box, entry 0 in the most significant byte.
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // ~b * 8 addresses entry b counted from the MSB end.
  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[{~b, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/aes_encr_iter_if.sv
// Block/ciphertext handshake bundle for aes_encr_iter.
//   in_valid/in_ready/in_data/in_key : plaintext + key offer
//   out_valid/out_ready/out_data     : ciphertext delivery
// master = block producer / ciphertext consumer, slave = the core.
interface aes_encr_iter_if;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_data;
  logic [127:0] in_key;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;

  modport master (
    output in_valid, in_data, in_key, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, in_key, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/aes_key_step.sv
// Combinational AES-128 key schedule step: next round key from the
// current round key and round constant.
//   key      in  128  current round key (w0..w3, w0 in [127:96])
//   rcon     in  8    round constant for the key being produced
//   key_next out 128  next round key
module aes_key_step
  import aes_pkg::*;
(
  input  logic [127:0] key,
  input  logic [7:0]   rcon,
  output logic [127:0] key_next
);

  logic [31:0] w0, w1, w2, w3, t, n0, n1, n2, n3;

  always_comb begin
    {w0, w1, w2, w3} = key;
    // SubWord(RotWord(w3)) ^ {rcon, 0, 0, 0}
    t  = {sbox(w3[23:16]), sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])}
         ^ {rcon, 24'h000000};
    n0 = w0 ^ t;
    n1 = w1 ^ n0;
    n2 = w2 ^ n1;
    n3 = w3 ^ n2;
    key_next = {n0, n1, n2, n3};
  end

endmodule

// File: rtl/aes_encr_iter.sv
// Iterative AES-128 encryptor: one round per clock, on-the-fly key
// expansion, valid/ready on both sides.
//   clk  in   rising-edge clock
//   rst  in   asynchronous active-high reset
//   bus  slave modport of aes_encr_iter_if (block in, ciphertext out)
//   busy out  high while a block is in RUN or DONE
module aes_encr_iter
  import aes_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  aes_encr_iter_if.slave  bus,
  output logic            busy
);

  state_t       fsm;
  logic [127:0] state_r, key_r, key_next, state_next;
  logic [127:0] sb_v, sr_v, mc_v;
  logic [3:0]   rnd;
  logic [7:0]   rcon;
  logic         out_valid_r, busy_r, accept;

  assign bus.in_ready  = (fsm == IDLE) || ((fsm == DONE) && bus.out_ready);
  assign accept        = bus.in_valid && bus.in_ready;
  assign bus.out_valid = out_valid_r;
  assign bus.out_data  = state_r;
  assign busy          = busy_r;

  aes_key_step u_key_step (
    .key      (key_r),
    .rcon     (rcon),
    .key_next (key_next)
  );

  // Round datapath; byte i of the state sits at [127-8i -: 8], column-major.
  always_comb begin
    sb_v = '0;
    sr_v = '0;
    mc_v = '0;
    for (int unsigned i = 0; i < 16; i++)
      sb_v[127-8*i -: 8] = sbox(state_r[127-8*i -: 8]);
    for (int unsigned c = 0; c < 4; c++)
      for (int unsigned r = 0; r < 4; r++)
        sr_v[127-8*(r+4*c) -: 8] = sb_v[127-8*(r+4*((c+r)%4)) -: 8];
    for (int unsigned c = 0; c < 4; c++) begin
      logic [7:0] a0, a1, a2, a3;
      a0 = sr_v[127-32*c -: 8];
      a1 = sr_v[119-32*c -: 8];
      a2 = sr_v[111-32*c -: 8];
      a3 = sr_v[103-32*c -: 8];
      mc_v[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      mc_v[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      mc_v[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      mc_v[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
    state_next = ((rnd == NR) ? sr_v : mc_v) ^ key_next;
  end

  // Acceptance is tested first: it can only occur in IDLE or in DONE with
  // the output handshake, so it covers both the fresh and pass-through loads.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm         <= IDLE;
      state_r     <= '0;
      key_r       <= '0;
      rnd         <= '0;
      rcon        <= RCON_INIT;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
    end else if (accept) begin
      fsm         <= RUN;
      state_r     <= bus.in_data ^ bus.in_key;
      key_r       <= bus.in_key;
      rnd         <= 4'd1;
      rcon        <= RCON_INIT;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b1;
    end else begin
      case (fsm)
        RUN: begin
          key_r   <= key_next;
          rcon    <= xtime(rcon);
          state_r <= state_next;
          if (rnd == NR) begin
            fsm         <= DONE;
            rnd         <= '0;
            out_valid_r <= 1'b1;
          end else begin
            rnd <= rnd + 4'd1;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            fsm         <= IDLE;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
